soc_multi_timer: RTL and testbench
==================================

# soc_multi_timer

Parametrised multi-channel interval timer, the next-generation Avalon-MM timer peripheral for the SoC. It provides NUM_CH independent down-counters, each with its own period, prescaler, snapshot and interrupt enable. Each channel supports one-shot and continuous modes. The block sits on the system interconnect as a memory-mapped slave and drives one combined interrupt line to the processor.

## Interface
- NUM_CH, 4: number of timer channels, 1..8.
- CNT_W, 32: counter, period and snapshot width, 8..32. Values are zero-extended to 32 bits on read.
- PRE_W, 16: prescaler width, 1..16.
- DEFAULT_PERIOD, 49: period and counter value after reset.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  clog2(NUM_CH)+3  word address = {channel, reg[2:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR of all channel interrupts.

## Operation
Per-channel registers, selected by reg[2:0]:
- 0 STATUS
  - Read: {30'b0, RUN, TO}.
  - Any write clears TO.
- 1 CONTROL
  - Read: {28'b0, STOP, START, CONT, ITO}.
  - START and STOP are write-only pulses and always read as 0.
- 2 PERIOD
  - Read/write, CNT_W bits.
  - A write forces a reload of the counter and stops the channel.
- 3 PRESCALE
  - Read/write, PRE_W bits.
  - The counter ticks once every PRESCALE+1 clocks.
- 4 SNAPSHOT
  - A write of any data captures the live counter value.
  - A read returns the captured value.
- 5 IRQ_PENDING
  - Read-only, global, identical at every channel index.
  - Bit n = channel n irq.
- 6, 7 and any channel index ≥ NUM_CH: read 0, writes ignored.

Per-channel behaviour:
- The prescaler counter pre runs only while RUN=1.
  - tick = RUN && (pre == PRESCALE).
  - On tick, pre goes to 0; otherwise pre increments.
- On tick with count != 0: count decrements by 1.
- On tick with count == 0:
  - count reloads to PERIOD and TO is set.
  - If CONT=0, RUN clears.
- A CONTROL write with START=1 sets RUN and clears pre. The counter resumes from its current value.
- A CONTROL write with STOP=1 clears RUN. If START and STOP are both set, STOP wins.
- A PERIOD write loads count from the new value on the next cycle, clears pre and clears RUN.
- PRESCALE writes take effect on the next cycle. If pre > the new PRESCALE, pre wraps to 0 at the next clock.
- Channel irq = TO && ITO. Top-level irq is the OR across channels, combinational from registers.

Boundary rules:
- PERIOD=0 with CONT=1: TO is set on every tick.
- STATUS clear and timeout in the same cycle: TO=1, because set wins.
- SNAPSHOT write on a tick cycle: captures the pre-tick value.
- Reset mid-count: all state returns to reset values immediately.

## Timing
- Reset values:
  - readdata = 0, irq = 0.
  - count = PERIOD = DEFAULT_PERIOD.
  - PRESCALE = 0, pre = 0.
  - TO = RUN = ITO = CONT = 0, snapshot = 0.
- Read latency: 1 cycle. readdata reflects the address and chipselect of the previous cycle. readdata is updated every cycle regardless of chipselect.
- Writes commit on the clock edge where the strobe is sampled. Register side effects are visible to reads issued in the next cycle.
- START write at edge T: the first tick occurs at edge T+PRESCALE+1.
- One-shot timeout: TO is set at edge T+(PERIOD+1)·(PRESCALE+1) after START, where T is the START edge. irq rises in the same cycle as TO.
- Continuous mode: the timeout interval is (PERIOD+1)·(PRESCALE+1) clocks.

## Test plan
- Reset, then read all registers of ch0 → STATUS=0, PERIOD=49, PRESCALE=0, SNAPSHOT=0, irq=0.
- ch1: PERIOD=4, PRESCALE=0, CONTROL=0x5 (START+ITO) → TO and irq set exactly 5 clocks after the START edge. RUN=0 afterwards; counter holds at 4.
- ch2: PERIOD=2, PRESCALE=3, CONTROL=0x7 (continuous) → TO sets every 12 clocks. Write STATUS → TO clears. Issue a STATUS write on a timeout cycle → TO remains 1.
- ch0: start with PERIOD=100; after 10 clocks write SNAPSHOT, then read it → 90. Write PERIOD=7 → RUN=0 and count=7.
- All channels running with ITO=1 → IRQ_PENDING = (1<<NUM_CH)-1. Clear each STATUS in turn → irq falls only after the last clear. CONTROL=0xC (START+STOP) → RUN=0.
- Assert reset mid-count on every channel → all outputs are 0 within the same cycle; count returns to 49.

Source files
------------

// File: rtl/soc_multi_timer_if.sv
// Memory-mapped slave bus of the multi-channel timer: word address,
// select, active-low write strobe, write data and registered read data.
interface soc_multi_timer_if #(
  parameter int ADDR_W = 5
) ();
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_multi_timer.sv
// NUM_CH independent prescaled down-counters behind a memory-mapped slave.
// Address = {channel, reg[2:0]}; one combined interrupt line.
module soc_multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int PRE_W          = 16,
  parameter int DEFAULT_PERIOD = 49
) (
  input  logic             clk,
  input  logic             reset,
  soc_multi_timer_if.slave bus,
  output logic             irq
);

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_SNAPSHOT = 3'd4;
  localparam logic [2:0] REG_IRQ_PEND = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};

  // Address split; widening to 32 bits keeps NUM_CH=1 (no channel field) legal.
  logic [31:0] addr_ext_s;
  logic [28:0] ch_s;
  logic [2:0]  reg_s;
  logic        wr_s;
  logic [31:0] wdata_s;

  assign addr_ext_s = 32'(bus.address);
  assign ch_s       = addr_ext_s[31:3];
  assign reg_s      = addr_ext_s[2:0];
  assign wr_s       = bus.chipselect && !bus.write_n;
  assign wdata_s    = bus.writedata;

  // Per-channel state
  logic [CNT_W-1:0] count_r    [NUM_CH];
  logic [CNT_W-1:0] period_r   [NUM_CH];
  logic [CNT_W-1:0] snap_r     [NUM_CH];
  logic [PRE_W-1:0] pre_r      [NUM_CH];
  logic [PRE_W-1:0] prescale_r [NUM_CH];
  logic [NUM_CH-1:0] run_r;
  logic [NUM_CH-1:0] to_r;
  logic [NUM_CH-1:0] ito_r;
  logic [NUM_CH-1:0] cont_r;

  // Per-channel decode
  logic [NUM_CH-1:0] wr_status_s;
  logic [NUM_CH-1:0] wr_control_s;
  logic [NUM_CH-1:0] wr_period_s;
  logic [NUM_CH-1:0] wr_prescale_s;
  logic [NUM_CH-1:0] wr_snap_s;
  logic [NUM_CH-1:0] tick_s;
  logic [NUM_CH-1:0] expire_s;
  logic [NUM_CH-1:0] irq_vec_s;

  // Read-side channel mux
  logic             hit_s;
  logic             ch_valid_s;
  logic             sel_run_s;
  logic             sel_to_s;
  logic             sel_ito_s;
  logic             sel_cont_s;
  logic [CNT_W-1:0] sel_period_s;
  logic [CNT_W-1:0] sel_snap_s;
  logic [PRE_W-1:0] sel_prescale_s;
  logic [31:0]      rdata_s;

  // Write strobes per channel/register, prescaler tick and timeout detection.
  always_comb begin
    wr_status_s   = {NUM_CH{1'b0}};
    wr_control_s  = {NUM_CH{1'b0}};
    wr_period_s   = {NUM_CH{1'b0}};
    wr_prescale_s = {NUM_CH{1'b0}};
    wr_snap_s     = {NUM_CH{1'b0}};
    tick_s        = {NUM_CH{1'b0}};
    expire_s      = {NUM_CH{1'b0}};
    irq_vec_s     = {NUM_CH{1'b0}};
    for (int n = 0; n < NUM_CH; n++) begin
      wr_status_s[n]   = wr_s && (ch_s == 29'(n)) && (reg_s == REG_STATUS);
      wr_control_s[n]  = wr_s && (ch_s == 29'(n)) && (reg_s == REG_CONTROL);
      wr_period_s[n]   = wr_s && (ch_s == 29'(n)) && (reg_s == REG_PERIOD);
      wr_prescale_s[n] = wr_s && (ch_s == 29'(n)) && (reg_s == REG_PRESCALE);
      wr_snap_s[n]     = wr_s && (ch_s == 29'(n)) && (reg_s == REG_SNAPSHOT);
      tick_s[n]        = run_r[n] && (pre_r[n] == prescale_r[n]);
      expire_s[n]      = tick_s[n] && (count_r[n] == CNT_ZERO);
      irq_vec_s[n]     = to_r[n] && ito_r[n];
    end
  end

  assign irq = |irq_vec_s;

  // Channel state: PERIOD write beats everything, STOP beats START, TO set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        count_r[n]    <= CNT_RST;
        period_r[n]   <= CNT_RST;
        snap_r[n]     <= CNT_ZERO;
        pre_r[n]      <= PRE_ZERO;
        prescale_r[n] <= PRE_ZERO;
      end
      run_r  <= {NUM_CH{1'b0}};
      to_r   <= {NUM_CH{1'b0}};
      ito_r  <= {NUM_CH{1'b0}};
      cont_r <= {NUM_CH{1'b0}};
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_period_s[n]) begin
          period_r[n] <= wdata_s[CNT_W-1:0];
          count_r[n]  <= wdata_s[CNT_W-1:0];
        end else if (expire_s[n]) begin
          count_r[n] <= period_r[n];
        end else if (tick_s[n]) begin
          count_r[n] <= count_r[n] - CNT_ONE;
        end

        // pre above a freshly lowered PRESCALE wraps to 0 instead of running to overflow.
        if (wr_period_s[n] || (wr_control_s[n] && wdata_s[2])) begin
          pre_r[n] <= PRE_ZERO;
        end else if (run_r[n]) begin
          if (pre_r[n] >= prescale_r[n]) begin
            pre_r[n] <= PRE_ZERO;
          end else begin
            pre_r[n] <= pre_r[n] + PRE_ONE;
          end
        end

        if (wr_period_s[n]) begin
          run_r[n] <= 1'b0;
        end else if (wr_control_s[n] && wdata_s[3]) begin
          run_r[n] <= 1'b0;
        end else if (wr_control_s[n] && wdata_s[2]) begin
          run_r[n] <= 1'b1;
        end else if (expire_s[n] && !cont_r[n]) begin
          run_r[n] <= 1'b0;
        end

        if (expire_s[n]) begin
          to_r[n] <= 1'b1;
        end else if (wr_status_s[n]) begin
          to_r[n] <= 1'b0;
        end

        if (wr_control_s[n]) begin
          ito_r[n]  <= wdata_s[0];
          cont_r[n] <= wdata_s[1];
        end

        if (wr_prescale_s[n]) begin
          prescale_r[n] <= wdata_s[PRE_W-1:0];
        end

        // Snapshot takes the counter as it was before this edge's tick.
        if (wr_snap_s[n]) begin
          snap_r[n] <= count_r[n];
        end
      end
    end
  end

  // AND-OR mux of the addressed channel's registers.
  always_comb begin
    hit_s          = 1'b0;
    ch_valid_s     = 1'b0;
    sel_run_s      = 1'b0;
    sel_to_s       = 1'b0;
    sel_ito_s      = 1'b0;
    sel_cont_s     = 1'b0;
    sel_period_s   = CNT_ZERO;
    sel_snap_s     = CNT_ZERO;
    sel_prescale_s = PRE_ZERO;
    for (int n = 0; n < NUM_CH; n++) begin
      hit_s          = (ch_s == 29'(n));
      ch_valid_s     = ch_valid_s | hit_s;
      sel_run_s      = sel_run_s  | (hit_s & run_r[n]);
      sel_to_s       = sel_to_s   | (hit_s & to_r[n]);
      sel_ito_s      = sel_ito_s  | (hit_s & ito_r[n]);
      sel_cont_s     = sel_cont_s | (hit_s & cont_r[n]);
      sel_period_s   = sel_period_s   | ({CNT_W{hit_s}} & period_r[n]);
      sel_snap_s     = sel_snap_s     | ({CNT_W{hit_s}} & snap_r[n]);
      sel_prescale_s = sel_prescale_s | ({PRE_W{hit_s}} & prescale_r[n]);
    end
  end

  // Read data for the current address; out-of-range channels and regs 6/7 read 0.
  always_comb begin
    rdata_s = 32'd0;
    if (bus.chipselect && ch_valid_s) begin
      case (reg_s)
        REG_STATUS:   rdata_s = {30'd0, sel_run_s, sel_to_s};
        REG_CONTROL:  rdata_s = {28'd0, 2'b00, sel_cont_s, sel_ito_s};
        REG_PERIOD:   rdata_s = 32'(sel_period_s);
        REG_PRESCALE: rdata_s = 32'(sel_prescale_s);
        REG_SNAPSHOT: rdata_s = 32'(sel_snap_s);
        REG_IRQ_PEND: rdata_s = 32'(irq_vec_s);
        default:      rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.readdata <= 32'd0;
    end else begin
      bus.readdata <= rdata_s;
    end
  end

endmodule

// File: tb/tb_soc_multi_timer.sv
// Directed self-checking bench for soc_multi_timer (NUM_CH=4, defaults).
module tb_soc_multi_timer;

  localparam int ADDR_W = 5;

  logic clk;
  logic reset;
  logic irq;
  int   pass_cnt;
  int   total_cnt;

  soc_multi_timer_if #(.ADDR_W(ADDR_W)) bus ();

  soc_multi_timer #(
    .NUM_CH(4),
    .CNT_W(32),
    .PRE_W(16),
    .DEFAULT_PERIOD(49)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One write: strobe driven at a negedge, committed at the following posedge.
  task automatic bus_write(input int ch, input int rsel, input logic [31:0] d);
    @(negedge clk);
    bus.address    = ADDR_W'((ch << 3) | rsel);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // One read: address presented for one cycle, readdata sampled a half cycle after the edge.
  task automatic bus_read(input int ch, input int rsel, output logic [31:0] d);
    @(negedge clk);
    bus.address    = ADDR_W'((ch << 3) | rsel);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else pass_cnt++;
    total_cnt++; if (bus.readdata !== 32'd0) $display("FAIL reset_readdata: got %h expected 0", bus.readdata); else pass_cnt++;
    reset = 1'b0;
    bus_read(0, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reset_status: got %h expected 0", rd); else pass_cnt++;
    bus_read(0, 1, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reset_control: got %h expected 0", rd); else pass_cnt++;
    bus_read(0, 2, rd);
    total_cnt++; if (rd !== 32'd49) $display("FAIL reset_period: got %0d expected 49", rd); else pass_cnt++;
    bus_read(0, 3, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reset_prescale: got %0d expected 0", rd); else pass_cnt++;
    bus_read(0, 4, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reset_snapshot: got %0d expected 0", rd); else pass_cnt++;
    bus_read(0, 5, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reset_irq_pending: got %h expected 0", rd); else pass_cnt++;
    bus_write(0, 4, 32'd0);
    bus_read(0, 4, rd);
    total_cnt++; if (rd !== 32'd49) $display("FAIL reset_count: got %0d expected 49", rd); else pass_cnt++;
    bus_write(0, 6, 32'hFFFF_FFFF);
    bus_read(0, 6, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL reg6_reads_zero: got %h expected 0", rd); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq_after: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    bus_write(1, 2, 32'd4);
    bus_write(1, 3, 32'd0);
    bus_write(1, 1, 32'h5);
    // Now half a cycle after the START edge T; timeout lands on edge T+5.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total_cnt++;
      if (irq !== (k == 5)) $display("FAIL oneshot_irq_k%0d: got %b expected %b", k, irq, (k == 5));
      else pass_cnt++;
    end
    bus_read(1, 0, rd);
    total_cnt++; if (rd !== 32'd1) $display("FAIL oneshot_status: got %h expected 1", rd); else pass_cnt++;
    bus_read(1, 1, rd);
    total_cnt++; if (rd !== 32'd1) $display("FAIL oneshot_control: got %h expected 1", rd); else pass_cnt++;
    bus_write(1, 4, 32'd0);
    bus_read(1, 4, rd);
    total_cnt++; if (rd !== 32'd4) $display("FAIL oneshot_count_hold: got %0d expected 4", rd); else pass_cnt++;
    bus_read(1, 5, rd);
    total_cnt++; if (rd !== 32'h2) $display("FAIL oneshot_irq_pending: got %h expected 2", rd); else pass_cnt++;
    bus_write(1, 0, 32'd0);
    total_cnt++; if (irq !== 1'b0) $display("FAIL oneshot_clear: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_continuous();
    logic [31:0] rd;
    bus_write(2, 2, 32'd2);
    bus_write(2, 3, 32'd3);
    bus_write(2, 1, 32'h7);
    // START edge T; timeouts at T+12, T+24, ...
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k >= 11) begin
        total_cnt++;
        if (irq !== (k == 12)) $display("FAIL cont_first_irq_k%0d: got %b expected %b", k, irq, (k == 12));
        else pass_cnt++;
      end
    end
    bus_write(2, 0, 32'd0);             // commits at T+14
    total_cnt++; if (irq !== 1'b0) $display("FAIL cont_status_clear: got %b expected 0", irq); else pass_cnt++;
    repeat (8) @(negedge clk);          // just after T+22
    total_cnt++; if (irq !== 1'b0) $display("FAIL cont_before_second: got %b expected 0", irq); else pass_cnt++;
    bus_write(2, 0, 32'd0);             // commits at T+24, same edge as the timeout
    total_cnt++; if (irq !== 1'b1) $display("FAIL cont_set_wins: got %b expected 1", irq); else pass_cnt++;
    bus_read(2, 0, rd);
    total_cnt++; if (rd !== 32'd3) $display("FAIL cont_status_running: got %h expected 3", rd); else pass_cnt++;
    bus_write(2, 1, 32'h8);
    bus_write(2, 0, 32'd0);
    bus_read(2, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL cont_stopped: got %h expected 0", rd); else pass_cnt++;
  endtask

  task automatic test_snapshot();
    logic [31:0] rd;
    bus_write(0, 2, 32'd100);
    bus_write(0, 1, 32'h4);
    // START edge T: count is 100-k after edge T+k; a snapshot at edge T+11 sees 90.
    repeat (9) @(negedge clk);
    bus_write(0, 4, 32'hDEAD_BEEF);
    bus_read(0, 4, rd);
    total_cnt++; if (rd !== 32'd90) $display("FAIL snapshot_value: got %0d expected 90", rd); else pass_cnt++;
    bus_write(0, 2, 32'd7);
    bus_read(0, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL period_write_stops: got %h expected 0", rd); else pass_cnt++;
    repeat (3) @(negedge clk);
    bus_write(0, 4, 32'd0);
    bus_read(0, 4, rd);
    total_cnt++; if (rd !== 32'd7) $display("FAIL period_write_reload: got %0d expected 7", rd); else pass_cnt++;
  endtask

  task automatic test_all_irq();
    logic [31:0] rd;
    for (int n = 0; n < 4; n++) begin
      bus_write(n, 2, 32'd1);
      bus_write(n, 1, 32'h5);
    end
    repeat (3) @(negedge clk);
    bus_read(3, 5, rd);
    total_cnt++; if (rd !== 32'hF) $display("FAIL all_pending_ch3: got %h expected f", rd); else pass_cnt++;
    bus_read(0, 5, rd);
    total_cnt++; if (rd !== 32'hF) $display("FAIL all_pending_ch0: got %h expected f", rd); else pass_cnt++;
    for (int n = 0; n < 4; n++) begin
      bus_write(n, 0, 32'd0);
      total_cnt++;
      if (irq !== (n < 3)) $display("FAIL all_clear_ch%0d: got %b expected %b", n, irq, (n < 3));
      else pass_cnt++;
    end
    bus_write(0, 1, 32'hC);
    bus_read(0, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL start_stop_status: got %h expected 0", rd); else pass_cnt++;
    bus_read(0, 1, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL start_stop_control: got %h expected 0", rd); else pass_cnt++;
  endtask

  task automatic test_period_zero();
    logic [31:0] rd;
    bus_write(3, 2, 32'd0);
    bus_write(3, 1, 32'h7);
    @(negedge clk);
    total_cnt++; if (irq !== 1'b1) $display("FAIL pz_first: got %b expected 1", irq); else pass_cnt++;
    bus_write(3, 0, 32'd0);
    total_cnt++; if (irq !== 1'b1) $display("FAIL pz_clear1: got %b expected 1", irq); else pass_cnt++;
    bus_write(3, 0, 32'd0);
    total_cnt++; if (irq !== 1'b1) $display("FAIL pz_clear2: got %b expected 1", irq); else pass_cnt++;
    bus_write(3, 1, 32'h8);
    bus_write(3, 0, 32'd0);
    bus_read(3, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL pz_stopped: got %h expected 0", rd); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL pz_irq_off: got %b expected 0", irq); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(0, 2, 32'd0);
    bus_write(0, 1, 32'h7);
    bus_write(1, 2, 32'd20);
    bus_write(1, 1, 32'h4);
    @(negedge clk);
    bus.address    = ADDR_W'((1 << 3) | 2);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.readdata !== 32'd20) $display("FAIL mid_pre_readdata: got %0d expected 20", bus.readdata); else pass_cnt++;
    total_cnt++; if (irq !== 1'b1) $display("FAIL mid_pre_irq: got %b expected 1", irq); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (bus.readdata !== 32'd0) $display("FAIL mid_readdata: got %h expected 0", bus.readdata); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b expected 0", irq); else pass_cnt++;
    @(negedge clk);
    bus.chipselect = 1'b0;
    reset = 1'b0;
    bus_read(1, 2, rd);
    total_cnt++; if (rd !== 32'd49) $display("FAIL mid_period: got %0d expected 49", rd); else pass_cnt++;
    bus_read(1, 0, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL mid_status: got %h expected 0", rd); else pass_cnt++;
    bus_write(1, 4, 32'd0);
    bus_read(1, 4, rd);
    total_cnt++; if (rd !== 32'd49) $display("FAIL mid_count: got %0d expected 49", rd); else pass_cnt++;
    bus_read(0, 1, rd);
    total_cnt++; if (rd !== 32'd0) $display("FAIL mid_control: got %h expected 0", rd); else pass_cnt++;
    total_cnt++; if (irq !== 1'b0) $display("FAIL mid_irq_after: got %b expected 0", irq); else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    test_reset();
    test_oneshot();
    test_continuous();
    test_snapshot();
    test_all_irq();
    test_period_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
